dot_product: RTL and testbench

DOT_PRODUCT -- requirements
Module: dot_product

---
 rtl/dot_product_pkg.sv | 18 +
 rtl/dot_product_if.sv | 25 ++
 rtl/sat_q32.sv | 24 ++
 rtl/dot_product.sv | 114 +++++++++++
 tb/tb_dot_product.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/dot_product_pkg.sv
// Shared fixed-point math definitions: operand widths, default Q format and FSM encoding.
package dot_product_pkg;

  localparam int unsigned QBitsDefault = 16;
  localparam int unsigned DataW        = 32;
  localparam int unsigned AccW         = 66;
  localparam int unsigned VecLen       = 3;

  typedef logic [DataW-1:0]              word_t;
  typedef logic [VecLen-1:0][DataW-1:0]  vec_t;
  typedef logic signed [AccW-1:0]        acc_t;

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StMac   = 2'd1;
  localparam state_t StWrite = 2'd2;

endpackage

// File: rtl/dot_product_if.sv
// FIFO-side handshake bundle for the dot-product stage: input FIFO pop side and output FIFO push side.
interface dot_product_if;
  import dot_product_pkg::*;

  vec_t  x;
  vec_t  y;
  logic  in_empty;
  logic  in_rd_en;
  word_t out;
  logic  out_ovf;
  logic  out_full;
  logic  out_wr_en;

  // master: the surrounding FIFOs / environment; slave: the dot-product stage
  modport master (
    output x, y, in_empty, out_full,
    input  in_rd_en, out, out_ovf, out_wr_en
  );

  modport slave (
    input  x, y, in_empty, out_full,
    output in_rd_en, out, out_ovf, out_wr_en
  );

endinterface

// File: rtl/sat_q32.sv
// Saturates a 66-bit signed value to the signed 32-bit range, flagging any clipping.
module sat_q32
  import dot_product_pkg::*;
(
  input  acc_t  din,
  output word_t dout,
  output logic  ovf
);

  logic fits;

  // Fits when every bit above bit 31 is a copy of the sign bit.
  assign fits = (&din[AccW-1:DataW-1]) | ~(|din[AccW-1:DataW-1]);

  always_comb begin
    dout = din[DataW-1:0];
    ovf  = 1'b0;
    if (!fits) begin
      dout = din[AccW-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      ovf  = 1'b1;
    end
  end

endmodule

// File: rtl/dot_product.sv
// Three-element signed fixed-point dot product: pop one FIFO entry, MAC over three cycles with one
// shared multiplier, then push a saturated Q-format result.
module dot_product
  import dot_product_pkg::*;
#(
  parameter int unsigned Q_BITS = QBitsDefault
) (
  input  logic         clock,
  input  logic         reset,
  dot_product_if.slave bus
);

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  acc_t        acc_q, acc_d;
  vec_t        xr_q, xr_d, yr_q, yr_d;
  word_t       out_q, out_d;
  logic        ovf_q, ovf_d;

  word_t       x_sel, y_sel;
  logic signed [2*DataW-1:0] prod;
  acc_t        acc_sum, acc_shift;
  word_t       sat_out;
  logic        sat_ovf;
  logic        pop, push;

  always_comb begin
    x_sel = xr_q[0];
    y_sel = yr_q[0];
    if (idx_q == 2'd1) begin
      x_sel = xr_q[1];
      y_sel = yr_q[1];
    end else if (idx_q == 2'd2) begin
      x_sel = xr_q[2];
      y_sel = yr_q[2];
    end
  end

  assign prod      = $signed(x_sel) * $signed(y_sel);
  assign acc_sum   = acc_q + acc_t'(prod);
  assign acc_shift = acc_sum >>> Q_BITS;

  sat_q32 u_sat (
    .din  (acc_shift),
    .dout (sat_out),
    .ovf  (sat_ovf)
  );

  // Gated by reset so no pop is requested while reset is held.
  assign pop  = reset && (state_q == StIdle) && !bus.in_empty;
  assign push = reset && (state_q == StWrite) && !bus.out_full;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    xr_d    = xr_q;
    yr_d    = yr_q;
    out_d   = out_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          xr_d    = bus.x;
          yr_d    = bus.y;
          acc_d   = '0;
          idx_d   = 2'd0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_sum;
        if (idx_q == 2'd2) begin
          idx_d   = 2'd0;
          out_d   = sat_out;
          ovf_d   = sat_ovf;
          state_d = StWrite;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      StWrite: begin
        if (push) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      acc_q   <= '0;
      xr_q    <= '0;
      yr_q    <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      xr_q    <= xr_d;
      yr_q    <= yr_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_rd_en  = pop;
  assign bus.out_wr_en = push;
  assign bus.out       = out_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_dot_product.sv
// Directed plus random scoreboard bench for dot_product with Q_BITS = 16.
module tb_dot_product;
  import dot_product_pkg::*;

  typedef struct packed {
    vec_t x;
    vec_t y;
  } entry_t;

  logic clock;
  logic reset;
  dot_product_if bus();

  dot_product #(.Q_BITS(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  entry_t      in_q[$];
  logic [32:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rd = 0;
  int pops = 0;
  int n_push = 0;
  bit will_pop = 0;
  bit lat_en = 0;
  bit rand_full = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    vec_t v;
    v[0] = a;
    v[1] = b;
    v[2] = c;
    return v;
  endfunction

  // Reference: exact 66-bit sum, floor shift by 16, clip to signed 32-bit.
  function automatic logic [32:0] model(input vec_t x, input vec_t y);
    logic signed [65:0] acc;
    logic signed [65:0] s;
    acc = '0;
    for (int i = 0; i < 3; i++) begin
      acc = acc + 66'($signed(x[i])) * 66'($signed(y[i]));
    end
    s = acc >>> 16;
    if (s > 66'sh7FFF_FFFF) return {1'b1, 32'h7FFF_FFFF};
    if (s < -66'sh8000_0000) return {1'b1, 32'h8000_0000};
    return {1'b0, s[31:0]};
  endfunction

  task automatic push(input vec_t x, input vec_t y, input logic [32:0] e);
    in_q.push_back('{x: x, y: y});
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget && (exp_q.size() != 0 || in_q.size() != 0); i++) @(negedge clock);
    check("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_pop();
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!bus.in_rd_en && k < 50);
    check("pop_seen", 64'(bus.in_rd_en), 64'd1);
  endtask

  // Monitor: outputs sampled on the falling edge.
  always @(negedge clock) begin
    logic [32:0] e;
    cyc++;
    if (reset) begin
      check("rd_wr_exclusive", 64'(bus.in_rd_en & bus.out_wr_en), 64'd0);
      if (bus.in_rd_en) begin
        pops++;
        last_rd  = cyc;
        will_pop = 1'b1;
      end
      if (bus.out_wr_en) begin
        check("push_has_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result", 64'({bus.out_ovf, bus.out}), 64'(e));
          if (lat_en) check("latency", 64'(cyc - last_rd), 64'd4);
        end
      end
    end
  end

  // Input FIFO model (first-word fall-through) and optional random back-pressure.
  always @(posedge clock) begin
    #1;
    if (will_pop) begin
      if (in_q.size() != 0) in_q.delete(0);
      will_pop = 1'b0;
    end
    if (in_q.size() != 0) begin
      bus.in_empty = 1'b0;
      bus.x        = in_q[0].x;
      bus.y        = in_q[0].y;
    end else begin
      bus.in_empty = 1'b1;
    end
    if (rand_full) bus.out_full = 1'($urandom_range(0, 1));
  end

  initial begin
    vec_t xv, yv;
    reset        = 1'b0;
    bus.out_full = 1'b0;
    bus.in_empty = 1'b1;
    bus.x        = '0;
    bus.y        = '0;

    // Reset state, with an entry already waiting in the input FIFO.
    push(mk(32'h1_0000, 32'h2_0000, 32'h3_0000), mk(32'h4_0000, 32'h5_0000, 32'h6_0000),
         {1'b0, 32'h0020_0000});
    repeat (3) @(negedge clock);
    check("rst_in_rd_en", 64'(bus.in_rd_en), 64'd0);
    check("rst_out_wr_en", 64'(bus.out_wr_en), 64'd0);
    check("rst_out", 64'(bus.out), 64'd0);
    check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
    lat_en = 1'b1;
    step();
    reset = 1'b1;

    // Directed values, back-to-back with no back-pressure.
    push(mk(32'hFFFE_8000, 32'h0, 32'h0), mk(32'h2_0000, 32'h0, 32'h0), {1'b0, 32'hFFFD_0000});
    push(mk(32'hFFFF_FFFF, 32'h0, 32'h0), mk(32'h1, 32'h0, 32'h0), {1'b0, 32'hFFFF_FFFF});
    push(mk(32'h7FFF_0000, 32'h7FFF_0000, 32'h0), mk(32'h7FFF_0000, 32'h7FFF_0000, 32'h0),
         {1'b1, 32'h7FFF_FFFF});
    push(mk(32'h7FFF_0000, 32'h7FFF_0000, 32'h0), mk(32'h8000_0000, 32'h8000_0000, 32'h0),
         {1'b1, 32'h8000_0000});
    wait_drain(200);
    repeat (2) @(negedge clock);

    // Output FIFO full while a result waits in WRITE.
    lat_en = 1'b0;
    step();
    bus.out_full = 1'b1;
    push(mk(32'h1_0000, 32'h2_0000, 32'h3_0000), mk(32'h4_0000, 32'h5_0000, 32'h6_0000),
         {1'b0, 32'h0020_0000});
    push(mk(32'hFFFE_8000, 32'h0, 32'h0), mk(32'h2_0000, 32'h0, 32'h0), {1'b0, 32'hFFFD_0000});
    wait_pop();
    repeat (4) @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      check("full_no_rd", 64'(bus.in_rd_en), 64'd0);
      check("full_no_wr", 64'(bus.out_wr_en), 64'd0);
      check("full_out_hold", 64'({bus.out_ovf, bus.out}), 64'({1'b0, 32'h0020_0000}));
      @(negedge clock);
    end
    step();
    bus.out_full = 1'b0;
    @(negedge clock);
    check("release_wr", 64'(bus.out_wr_en), 64'd1);
    @(negedge clock);
    check("release_rd_next", 64'(bus.in_rd_en), 64'd1);
    wait_drain(200);
    repeat (2) @(negedge clock);

    // Reset pulse during MAC index 1 abandons the in-flight result.
    lat_en = 1'b1;
    xv = mk(32'h0001_8000, 32'hFFFF_0000, 32'h0002_0000);
    yv = mk(32'h0003_0000, 32'h0000_4000, 32'hFFFC_0000);
    push(xv, yv, model(xv, yv));
    xv = mk(32'h0000_C000, 32'h0005_0000, 32'hFFF0_0000);
    yv = mk(32'h0002_0000, 32'hFFFF_8000, 32'h0000_1000);
    push(xv, yv, model(xv, yv));
    wait_pop();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete(0);
    @(negedge clock);
    check("mid_rst_out", 64'(bus.out), 64'd0);
    check("mid_rst_ovf", 64'(bus.out_ovf), 64'd0);
    check("mid_rst_rd", 64'(bus.in_rd_en), 64'd0);
    check("mid_rst_wr", 64'(bus.out_wr_en), 64'd0);
    step();
    reset = 1'b1;
    wait_drain(200);
    repeat (2) @(negedge clock);

    // Random stream with random back-pressure.
    lat_en    = 1'b0;
    rand_full = 1'b1;
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (n % 3 == 0) begin
          xv[i] = $urandom;
          yv[i] = $urandom;
        end else begin
          xv[i] = 32'($signed(18'($urandom)));
          yv[i] = 32'($signed(20'($urandom)));
        end
      end
      push(xv, yv, model(xv, yv));
    end
    wait_drain(5000);
    rand_full    = 1'b0;
    bus.out_full = 1'b0;
    repeat (10) @(negedge clock);
    check("pop_count", 64'(pops), 64'(n_push));
    check("exp_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
